// File: rtl/fifo_read_adapter.sv
// Read-side adapter: dual-clock FIFO read port (1-cycle registered dout_b) to a valid/ready stream via a skid buffer.
// Optional transfer counter rd_count when FIFO_RD_STATS_EN is defined.
module fifo_read_adapter #(
  parameter int FIFO_WIDTH = 16,
  parameter int BUF_DEPTH  = 2,
  parameter int LVL_WIDTH  = 4
) (
  input  logic                  clk_b,
  input  logic                  rst_n,
  input  logic                  empty,
  input  logic [FIFO_WIDTH-1:0] dout_b,
  output logic                  ren_b,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [LVL_WIDTH-1:0]  buf_level
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]           rd_count
`endif
);

  localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int SUM_W = LVL_WIDTH + 1;

  logic [FIFO_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [IDX_W-1:0]      rd_idx_q;
  logic [IDX_W-1:0]      wr_idx_q;
  logic [LVL_WIDTH-1:0]  level_q;
  logic [LVL_WIDTH-1:0]  level_d;
  logic                  inflight_q;
  logic                  pop;
  logic [SUM_W-1:0]      occ;

  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(BUF_DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign m_valid   = (level_q != '0);
  assign m_data    = mem_q[rd_idx_q];
  assign pop       = m_valid && m_ready;
  assign buf_level = level_q;

  // Occupancy once the in-flight word lands and this cycle's pop retires; a read is
  // only issued if its word is guaranteed a free slot next cycle.
  assign occ   = SUM_W'(level_q) + SUM_W'(inflight_q) - SUM_W'(pop);
  assign ren_b = rst_n && !empty && (occ < SUM_W'(BUF_DEPTH));

  always_comb begin
    level_d = level_q;
    case ({inflight_q, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      level_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= ren_b;
      if (inflight_q) begin
        mem_q[wr_idx_q] <= dout_b;
        wr_idx_q        <= idx_next(wr_idx_q);
      end
      if (pop) rd_idx_q <= idx_next(rd_idx_q);
      level_q <= level_d;
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk_b) begin
    if (!rst_n) rd_count <= '0;
    else if (pop) rd_count <= rd_count + 32'd1;
  end
`endif

endmodule
